alu_rr_sched: RTL and testbench
===============================

// Module: alu_rr_sched
// PURPOSE
// - Shares one combinational 32-bit ALU (sel 000 add, 001 sub, 010 mul, 011 div,
//   100 and, 101 or, 110 xor, 111 nand; 64-bit result) among NUM_REQ requesters.
// - Arbitrates requests round-robin, drives the shared ALU operands from registers,
//   and holds them for an op-dependent number of cycles.
// - Returns the registered 64-bit result with the winning requester's id.
// - Sits between requester front-ends and the ALU instance; the ALU stays stateless.
// PARAMETERS
// - NUM_REQ  4  number of requesters (2..8)
// - ID_W     2  width of rsp_id; must be >= clog2(NUM_REQ)
// - MUL_LAT  2  cycles the operands are held for sel 010 (>= 1)
// - DIV_LAT  4  cycles the operands are held for sel 011 (>= 1); all other ops take 1
// PORTS
// - clk        in   1          rising-edge clock
// - rst_n      in   1          asynchronous, active-low reset
// - req_valid  in   NUM_REQ    per-requester request valid
// - req_ready  out  NUM_REQ    one-hot grant/accept; combinational
// - req_a      in   32*NUM_REQ operand a; requester i at [32*i +: 32]
// - req_b      in   32*NUM_REQ operand b; same packing as req_a
// - req_sel    in   3*NUM_REQ  opcode; requester i at [3*i +: 3]
// - alu_a      out  32         operand a to the shared ALU (registered)
// - alu_b      out  32         operand b to the shared ALU (registered)
// - alu_sel    out  3          opcode to the shared ALU (registered)
// - alu_out    in   64         result from the shared ALU
// - rsp_valid  out  1          result valid
// - rsp_ready  in   1          result consumer ready
// - rsp_data   out  64         captured result
// - rsp_id     out  ID_W       index of the requester that owns rsp_data
// - busy       out  1          high in EXEC or RESP
// BEHAVIOUR
// - Reset values: state IDLE; alu_a, alu_b, alu_sel, rsp_data, rsp_id = 0;
//   rsp_valid = 0; busy = 0; last_grant = NUM_REQ-1; req_ready = 0 while rst_n is low.
// - FSM IDLE -> EXEC -> RESP -> IDLE. One transaction in flight; no pipelining.
// - IDLE:
//   - g = first i with req_valid[i], searching last_grant+1 upward and wrapping mod NUM_REQ.
//   - If any request is valid: req_ready = one-hot(g) in the same cycle.
//   - At the clock edge: capture a, b and sel of g into alu_*, set rsp_id = g and
//     last_grant = g, load cnt = lat(sel)-1, go to EXEC.
//   - If no request is valid: req_ready = 0 and the FSM stays in IDLE.
// - req_ready is always 0 outside IDLE; requesters hold valid and data until they see ready.
// - EXEC:
//   - alu_* are stable. When cnt != 0, decrement cnt.
//   - When cnt == 0: rsp_data <= alu_out, go to RESP.
//   - lat(sel): MUL_LAT for 010, DIV_LAT for 011, 1 otherwise.
// - RESP:
//   - rsp_valid = 1; rsp_data and rsp_id are held.
//   - When rsp_valid && rsp_ready: clear rsp_valid and go to IDLE.
//   - The next grant happens in the following IDLE cycle, so minimum spacing is 3 cycles.
// - Timing: result is valid lat+1 cycles after the accept edge.
// - alu_* keep their last values after a transaction; there is no clearing.
// - Fairness:
//   - With all requesters valid, grants rotate 0,1,2,3,0,...
//   - A request that drops before it is granted is ignored; no state is kept for it.
// - Width rules:
//   - Results are taken verbatim from alu_out (64-bit).
//   - The scheduler never inspects or modifies data, except under ALU_RR_SCHED_DZ_EN.
// - Asserting rst_n low mid-transaction forces IDLE asynchronously; the in-flight op is
//   dropped with no response. Requesters must re-issue.
// - A new request arriving while busy simply waits; it is not an error.
// CONFIGURATION
// - ALU_RR_SCHED_DZ_EN defined:
//   - A sel 011 request with b == 0 skips EXEC: go IDLE -> RESP directly.
//   - rsp_data = 64'hFFFF_FFFF_FFFF_FFFF.
//   - Extra output port rsp_dz (1 bit, reset 0) is 1 alongside that response and 0 for
//     all other responses.
// - Not defined: no rsp_dz port; divide-by-zero is sent to the ALU like any other op and
//   its result is returned as-is.
// TESTING
// - Single add: req0 a=5, b=7, sel=000
//   -> ready0 high in the accept cycle; rsp_valid 2 cycles later; rsp_data=12, rsp_id=0.
// - Mul latency: req2 a=32'hFFFF_FFFF, b=2, sel=010, MUL_LAT=2
//   -> alu_* stable for 2 cycles; rsp_data=64'h1_FFFF_FFFE, rsp_id=2.
// - Round-robin: all 4 requesters valid continuously, rsp_ready=1
//   -> grant order 0,1,2,3,0; no requester is granted twice before another valid one.
// - Backpressure: rsp_ready=0 for 5 cycles
//   -> rsp_valid, rsp_data and rsp_id held; req_ready stays 0; one grant after release.
// - Reset mid-DIV: rst_n low in the 2nd EXEC cycle
//   -> rsp_valid=0 and busy=0 immediately; after release the pending request is regranted.
// - DZ_EN build: req1 a=9, b=0, sel=011
//   -> rsp_data all ones and rsp_dz=1; the next req1 9/3 returns 3 with rsp_dz=0.

Source files
------------

// File: rtl/alu_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : alu_rr_sched
//  Purpose  : Round-robin scheduler that shares one stateless 32-bit ALU
//             among NUM_REQ requesters. Operands are registered toward the
//             ALU and held for an op-dependent number of cycles. The 64-bit
//             result is returned with the owning requester's id.
//  Options  : ALU_RR_SCHED_DZ_EN - divide-by-zero requests bypass the ALU.
//             They answer all ones and flag the answer on rsp_dz.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    input  logic [3*NUM_REQ-1:0]   req_sel,
    output logic [31:0]            alu_a,
    output logic [31:0]            alu_b,
    output logic [2:0]             alu_sel,
    input  logic [63:0]            alu_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [63:0]            rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
`ifdef ALU_RR_SCHED_DZ_EN
   ,output logic                   rsp_dz
`endif
);

    // Counter holds lat-1, so it needs enough bits for the largest latency minus one.
    localparam int c_max_lat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_cnt_w   = (c_max_lat > 1) ? $clog2(c_max_lat) : 1;

    localparam logic [2:0] c_sel_mul = 3'b010;
    localparam logic [2:0] c_sel_div = 3'b011;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [ID_W-1:0]    r_last_grant;
    logic [31:0]        r_alu_a;
    logic [31:0]        r_alu_b;
    logic [2:0]         r_alu_sel;
    logic [63:0]        r_rsp_data;
    logic [ID_W-1:0]    r_rsp_id;

    logic               w_any;
    logic [ID_W-1:0]    w_gid;
    logic [31:0]        w_ga;
    logic [31:0]        w_gb;
    logic [2:0]         w_gsel;
    logic [c_cnt_w-1:0] w_lat_m1;

    // Requester index visited at step k of the search that starts after the last grant.
    function automatic int rr_idx(input logic [ID_W-1:0] last, input int k);
        return (int'(last) + k) % NUM_REQ;
    endfunction

    // Round-robin pick: first valid requester after the last grant, wrapping around.
    always_comb begin
        w_any  = 1'b0;
        w_gid  = '0;
        w_ga   = '0;
        w_gb   = '0;
        w_gsel = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_any && req_valid[rr_idx(r_last_grant, k)]) begin
                w_any  = 1'b1;
                w_gid  = ID_W'(rr_idx(r_last_grant, k));
                w_ga   = req_a[32*rr_idx(r_last_grant, k) +: 32];
                w_gb   = req_b[32*rr_idx(r_last_grant, k) +: 32];
                w_gsel = req_sel[3*rr_idx(r_last_grant, k) +: 3];
            end
        end
    end

    // Hold count for the winning opcode, stored as latency minus one.
    always_comb begin
        w_lat_m1 = '0;
        if (w_gsel == c_sel_mul) begin
            w_lat_m1 = c_cnt_w'(MUL_LAT - 1);
        end else if (w_gsel == c_sel_div) begin
            w_lat_m1 = c_cnt_w'(DIV_LAT - 1);
        end
    end

`ifdef ALU_RR_SCHED_DZ_EN
    logic w_dz;
    logic r_rsp_dz;

    // A divide with a zero divisor is answered without using the ALU.
    always_comb begin
        w_dz = (w_gsel == c_sel_div) && (w_gb == 32'd0);
    end

    assign rsp_dz = r_rsp_dz;
`endif

    // Grant is only offered from IDLE and never while reset is applied.
    always_comb begin
        req_ready = '0;
        if (rst_n && (r_state == c_st_idle) && w_any) begin
            req_ready = NUM_REQ'(1) << w_gid;
        end
    end

    // Transaction FSM: accept in IDLE, wait out the ALU latency in EXEC, hand off in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= '0;
            r_rsp_data   <= '0;
            r_rsp_id     <= '0;
`ifdef ALU_RR_SCHED_DZ_EN
            r_rsp_dz     <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_alu_a      <= w_ga;
                        r_alu_b      <= w_gb;
                        r_alu_sel    <= w_gsel;
                        r_rsp_id     <= w_gid;
                        r_last_grant <= w_gid;
                        r_cnt        <= w_lat_m1;
`ifdef ALU_RR_SCHED_DZ_EN
                        if (w_dz) begin
                            r_rsp_data <= '1;
                            r_rsp_dz   <= 1'b1;
                            r_state    <= c_st_resp;
                        end else begin
                            r_rsp_dz   <= 1'b0;
                            r_state    <= c_st_exec;
                        end
`else
                        r_state      <= c_st_exec;
`endif
                    end
                end
                c_st_exec: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end else begin
                        r_rsp_data <= alu_out;
                        r_state    <= c_st_resp;
                    end
                end
                c_st_resp: begin
                    if (rsp_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_valid = (r_state == c_st_resp);
    assign busy      = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_rr_sched
//  Purpose  : Self-checking bench for alu_rr_sched. It provides the shared
//             ALU, models the requesters, and keeps a scoreboard of expected
//             responses plus a round-robin grant model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rr_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 4;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sel;
    } op_t;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sel;
        logic [63:0] data;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [3*NUM_REQ-1:0]  req_sel;
    logic [31:0]           alu_a;
    logic [31:0]           alu_b;
    logic [2:0]            alu_sel;
    logic [63:0]           alu_out;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [63:0]           rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic                  busy;
`ifdef ALU_RR_SCHED_DZ_EN
    logic                  rsp_dz;
`endif

    op_t  pend[$];
    exp_t sb[$];
    int   glog[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   m_last = NUM_REQ - 1;
    bit   rsp_seen = 1'b0;

    // Reference ALU behaviour; a zero divisor yields a recognisable marker.
    function automatic logic [63:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] sel);
        case (sel)
            3'b000:  return 64'(a) + 64'(b);
            3'b001:  return 64'(a) - 64'(b);
            3'b010:  return 64'(a) * 64'(b);
            3'b011:  return (b == 32'd0) ? 64'hDEAD_BEEF_0BAD_F00D : 64'(a / b);
            3'b100:  return 64'(a & b);
            3'b101:  return 64'(a | b);
            3'b110:  return 64'(a ^ b);
            default: return 64'(~(a & b));
        endcase
    endfunction

    assign alu_out = alu_ref(alu_a, alu_b, alu_sel);

    alu_rr_sched #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_sel  (req_sel),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_out  (alu_out),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_id   (rsp_id),
        .busy     (busy)
`ifdef ALU_RR_SCHED_DZ_EN
       ,.rsp_dz   (rsp_dz)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int find_pend(input int id);
        for (int i = 0; i < pend.size(); i++) begin
            if (pend[i].id == id) return i;
        end
        return -1;
    endfunction

    // Each requester presents its oldest pending op and holds it until granted.
    task automatic drive_inputs();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int p;
            p = find_pend(i);
            if (p >= 0) begin
                req_valid[i]       = 1'b1;
                req_a[32*i +: 32]  = pend[p].a;
                req_b[32*i +: 32]  = pend[p].b;
                req_sel[3*i +: 3]  = pend[p].sel;
            end
        end
    endtask

    task automatic add_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] sel);
        pend.push_back('{id: id, a: a, b: b, sel: sel});
        drive_inputs();
    endtask

    // Per-cycle checks at the falling edge; returns the requester expected to be accepted.
    task automatic check_cycle(output int acc);
        bit                 idle;
        logic [NUM_REQ-1:0] exp_oh;
        idle = (sb.size() == 0);
        acc  = -1;
        check("busy", 64'(busy), 64'(!idle));
        if (!idle && !rsp_valid) begin
            check("hold_a",   64'(alu_a),   64'(sb[0].a));
            check("hold_b",   64'(alu_b),   64'(sb[0].b));
            check("hold_sel", 64'(alu_sel), 64'(sb[0].sel));
        end
        if (rsp_valid) begin
            if (idle) begin
                check("rsp_unexpected", 64'(1), 64'(0));
            end else begin
                check("rsp_data", rsp_data, sb[0].data);
                check("rsp_id", 64'(rsp_id), 64'(sb[0].id));
`ifdef ALU_RR_SCHED_DZ_EN
                check("rsp_dz", 64'(rsp_dz), 64'(sb[0].dz));
`endif
                if (!rsp_seen) begin
                    check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat + 1));
                    rsp_seen = 1'b1;
                end
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    rsp_seen = 1'b0;
                end
            end
        end
        if (idle) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int i;
                i = (m_last + k) % NUM_REQ;
                if (acc < 0 && req_valid[i]) acc = i;
            end
        end
        exp_oh = '0;
        if (acc >= 0) exp_oh[acc] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_oh));
        if (acc >= 0) begin
            int   p;
            exp_t e;
            p       = find_pend(acc);
            e.id    = acc;
            e.a     = pend[p].a;
            e.b     = pend[p].b;
            e.sel   = pend[p].sel;
            e.dz    = 1'b0;
`ifdef ALU_RR_SCHED_DZ_EN
            e.dz    = (e.sel == 3'b011) && (e.b == 32'd0);
`endif
            e.data  = e.dz ? 64'hFFFF_FFFF_FFFF_FFFF : alu_ref(e.a, e.b, e.sel);
            e.lat   = e.dz ? 0 : (e.sel == 3'b010) ? MUL_LAT : (e.sel == 3'b011) ? DIV_LAT : 1;
            e.acc   = cyc;
            sb.push_back(e);
            glog.push_back(acc);
            m_last  = acc;
        end
    endtask

    task automatic step();
        int acc;
        @(negedge clk);
        cyc++;
        check_cycle(acc);
        @(posedge clk);
        #1;
        if (acc >= 0) pend.delete(find_pend(acc));
        drive_inputs();
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((pend.size() != 0 || sb.size() != 0) && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) check("timeout", 64'(1), 64'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        rsp_seen = 1'b0;
        m_last   = NUM_REQ - 1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=%0t exp=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        pend.delete();
        // Single add, already valid during reset
        add_op(0, 32'd5, 32'd7, 3'b000);
        #12;
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_alu_a",     64'(alu_a),     64'(0));
        check("rst_alu_b",     64'(alu_b),     64'(0));
        check("rst_alu_sel",   64'(alu_sel),   64'(0));
        check("rst_rsp_data",  rsp_data,       64'(0));
        check("rst_rsp_id",    64'(rsp_id),    64'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        glog.delete();
        wait_idle(20);
        check("add_ngrant", 64'(glog.size()), 64'(1));
        check("add_value",  rsp_data,         64'd12);

        // Multiply with extended hold
        add_op(2, 32'hFFFF_FFFF, 32'd2, 3'b010);
        wait_idle(20);
        check("mul_value", rsp_data, 64'h1_FFFF_FFFE);
        check("mul_id",    64'(rsp_id), 64'(2));

        // Round-robin with all requesters continuously valid
        do_reset();
        glog.delete();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                add_op(i, $urandom, $urandom, 3'($urandom_range(4, 7)));
            end
        end
        wait_idle(200);
        check("rr_ngrant", 64'(glog.size()), 64'(8));
        for (int i = 0; i < glog.size(); i++) begin
            check("rr_order", 64'(glog[i]), 64'(i % NUM_REQ));
        end

        // Backpressure; requester 2 drops its request before it is ever granted
        rsp_ready = 1'b0;
        add_op(3, 32'h1234_5678, 32'h0F0F_0F0F, 3'b110);
        add_op(0, 32'hCAFE_F00D, 32'h00FF_FF00, 3'b100);
        step();
        step();
        add_op(2, 32'd77, 32'd11, 3'b001);
        step();
        step();
        pend.delete(find_pend(2));
        drive_inputs();
        repeat (5) step();
        rsp_ready = 1'b1;
        glog.delete();
        wait_idle(50);
        check("bp_grants_after", 64'(glog.size()), 64'(1));

        // Reset in the second EXEC cycle of a divide
        add_op(1, 32'd100, 32'd7, 3'b011);
        n = 0;
        while (sb.size() == 0 && n < 20) begin
            step();
            n++;
        end
        check("div_accepted", 64'(sb.size()), 64'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_busy",      64'(busy),      64'(0));
        check("mid_rst_alu_a",     64'(alu_a),     64'(0));
        add_op(1, 32'd100, 32'd7, 3'b011);
        #1;
        check("mid_rst_ready", 64'(req_ready), 64'(0));
        sb.delete();
        rsp_seen = 1'b0;
        m_last   = NUM_REQ - 1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        glog.delete();
        wait_idle(30);
        check("regrant_n",  64'(glog.size()), 64'(1));
        check("regrant_id", 64'(rsp_id),      64'(1));
        check("div_value",  rsp_data,         64'd14);

        // Divide by zero followed by a normal divide from the same requester
        add_op(1, 32'd9, 32'd0, 3'b011);
        wait_idle(30);
        add_op(1, 32'd9, 32'd3, 3'b011);
        wait_idle(30);
        check("div3_value", rsp_data, 64'd3);

        // Random traffic with random backpressure
        for (int i = 0; i < 40; i++) begin
            logic [31:0] b;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            add_op($urandom_range(0, NUM_REQ - 1), $urandom, b, 3'($urandom_range(0, 7)));
        end
        n = 0;
        while ((pend.size() != 0 || sb.size() != 0) && n < 3000) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
            n++;
        end
        if (n >= 3000) check("rand_timeout", 64'(1), 64'(0));
        rsp_ready = 1'b1;
        check("end_idle", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
